// File: rtl/uart_rx_word_fifo.sv
// uart_rx_word_fifo: packs UART bytes MSB-first into 32-bit words and queues them in a FIFO,
// with sticky overflow detection and an optional inter-byte timeout that drops partial words.
module uart_rx_word_fifo #(
    parameter int DEPTH_LOG2     = 4,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                  CLK,
    input  logic                  reset_n,
    input  logic [7:0]            receiver_data,
    input  logic                  receiver_valid,
    input  logic                  pop,
    input  logic                  clear_overflow,
    output logic [31:0]           input_data,
    output logic                  input_ready,
    output logic [DEPTH_LOG2:0]   count,
    output logic [1:0]            byte_phase,
    output logic                  overflow
);
    localparam int IW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [31:0]           r_mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] r_wr, r_rd;
    logic [DEPTH_LOG2:0]   r_count;
    logic [1:0]            r_phase;
    logic [23:0]           r_sr;
    logic [IW-1:0]         r_idle;
    logic                  r_ovf;
    logic                  w_push, w_pop, w_full, w_wr, w_timeout;

    assign w_push    = receiver_valid && r_phase == 2'd3;
    assign w_pop     = pop && input_ready;
    // count never exceeds the depth, so its MSB alone marks a full FIFO
    assign w_full    = r_count[DEPTH_LOG2];
    assign w_wr      = w_push && (!w_full || w_pop);
    // discard on the edge where the idle count would reach the limit; a byte strobe wins
    assign w_timeout = (TIMEOUT_CYCLES > 0) && !receiver_valid && r_phase != 2'd0
                       && (int'(r_idle) == TIMEOUT_CYCLES - 1);

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_phase <= '0;
            r_sr    <= '0;
            r_idle  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_wr)
                r_wr <= r_wr + DEPTH_LOG2'(1);
            if (w_pop)
                r_rd <= r_rd + DEPTH_LOG2'(1);
            if (w_wr && !w_pop)
                r_count <= r_count + (DEPTH_LOG2+1)'(1);
            else if (!w_wr && w_pop)
                r_count <= r_count - (DEPTH_LOG2+1)'(1);
            if (receiver_valid)
                r_phase <= r_phase + 2'd1;
            else if (w_timeout)
                r_phase <= 2'd0;
            if (receiver_valid && r_phase != 2'd3)
                r_sr <= {r_sr[15:0], receiver_data};
            else if (w_timeout)
                r_sr <= '0;
            r_idle <= (receiver_valid || r_phase == 2'd0 || w_timeout || TIMEOUT_CYCLES == 0)
                      ? '0 : r_idle + IW'(1);
            if (w_push && w_full && !w_pop)
                r_ovf <= 1'b1;
            else if (clear_overflow)
                r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_wr)
            r_mem[r_wr] <= {r_sr, receiver_data};
    end

    assign input_ready = |r_count;
    assign input_data  = input_ready ? r_mem[r_rd] : '0;
    assign count       = r_count;
    assign byte_phase  = r_phase;
    assign overflow    = r_ovf;
endmodule

// File: tb/tb_uart_rx_word_fifo.sv
// tb_uart_rx_word_fifo: scoreboard bench for the byte-to-word packer and word FIFO.
module tb_uart_rx_word_fifo;
    localparam int TO = 8;

    logic        CLK = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  receiver_data = '0;
    logic        receiver_valid = 1'b0;
    logic        pop = 1'b0;
    logic        clear_overflow = 1'b0;
    logic [31:0] input_data;
    logic        input_ready;
    logic [4:0]  count;
    logic [1:0]  byte_phase;
    logic        overflow;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] q[$];
    logic [23:0] m_sr;
    int          m_phase, m_idle;
    logic        m_ovf;

    uart_rx_word_fifo #(.DEPTH_LOG2(4), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .reset_n(reset_n), .receiver_data(receiver_data),
        .receiver_valid(receiver_valid), .pop(pop), .clear_overflow(clear_overflow),
        .input_data(input_data), .input_ready(input_ready), .count(count),
        .byte_phase(byte_phase), .overflow(overflow)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_sr = '0;
        m_phase = 0;
        m_idle = 0;
        m_ovf = 1'b0;
    endtask

    // one clock cycle of stimulus; the model predicts the state after the edge
    task automatic step(input logic v, input logic [7:0] b, input logic p, input logic clr);
        logic set;
        set = 1'b0;
        receiver_valid = v;
        receiver_data = b;
        pop = p;
        clear_overflow = clr;
        if (p && q.size() > 0)
            check("pop_data", input_data, q.pop_front());
        if (v) begin
            m_idle = 0;
            if (m_phase == 3) begin
                if (q.size() < 16) q.push_back({m_sr, b});
                else set = 1'b1;
                m_phase = 0;
            end else begin
                m_sr = {m_sr[15:0], b};
                m_phase++;
            end
        end else if (m_phase != 0) begin
            if (m_idle == TO - 1) begin
                m_phase = 0;
                m_idle = 0;
            end else m_idle++;
        end
        m_ovf = set ? 1'b1 : (clr ? 1'b0 : m_ovf);
        @(posedge CLK);
        #1;
        receiver_valid = 1'b0;
        pop = 1'b0;
        clear_overflow = 1'b0;
        check("count", 32'(count), q.size());
        check("ready", 32'(input_ready), 32'(q.size() > 0));
        check("phase", 32'(byte_phase), m_phase);
        check("ovf", 32'(overflow), 32'(m_ovf));
        if (q.size() > 0)
            check("head", input_data, q[0]);
    endtask

    task automatic send_word(input logic [31:0] w, input logic p0, input logic p3);
        for (int k = 0; k < 4; k++)
            step(1'b1, w[31-8*k -: 8], (k == 0 && p0) || (k == 3 && p3), 1'b0);
    endtask

    task automatic idle(input int n, input logic p);
        for (int k = 0; k < n; k++)
            step(1'b0, 8'h00, p, 1'b0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check("rst_ready", 32'(input_ready), 0);
        check("rst_count", 32'(count), 0);
        check("rst_phase", 32'(byte_phase), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_data", input_data, 32'h0);
        reset_n = 1'b1;
        @(posedge CLK);
        #1;

        send_word(32'hDEADBEEF, 1'b0, 1'b0);
        check("t1_data", input_data, 32'hDEADBEEF);
        check("t1_count", 32'(count), 1);
        idle(1, 1'b1);
        check("t1_empty", 32'(input_ready), 0);

        for (int i = 0; i <= 16; i++)
            send_word(32'(i), 1'b0, 1'b0);
        check("t2_full", 32'(count), 16);
        check("t2_ovf", 32'(overflow), 1);
        idle(16, 1'b1);
        check("t2_drained", 32'(input_ready), 0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("t2_clr", 32'(overflow), 0);

        for (int i = 0; i < 16; i++)
            send_word(32'hA500_0000 + 32'(i), 1'b0, 1'b0);
        send_word(32'hC0FFEE01, 1'b0, 1'b1);
        check("t3_count", 32'(count), 16);
        check("t3_ovf", 32'(overflow), 0);
        idle(15, 1'b1);
        check("t3_last", input_data, 32'hC0FFEE01);
        idle(1, 1'b1);

        for (int i = 0; i < 40; i++) begin
            send_word(32'h5A5A_0000 + 32'(i * 3), 1'b1, 1'b0);
            check("t4_le2", 32'(count <= 2), 1);
        end
        idle(1, 1'b1);
        check("t4_empty", 32'(input_ready), 0);

        step(1'b1, 8'hAA, 1'b0, 1'b0);
        step(1'b1, 8'hBB, 1'b0, 1'b0);
        idle(8, 1'b0);
        check("t5_phase0", 32'(byte_phase), 0);
        send_word(32'h11223344, 1'b0, 1'b0);
        check("t5_word", input_data, 32'h11223344);
        check("t5_count", 32'(count), 1);
        idle(1, 1'b1);
        step(1'b1, 8'h01, 1'b0, 1'b0);
        step(1'b1, 8'h02, 1'b0, 1'b0);
        idle(7, 1'b0);
        check("t5_keep", 32'(byte_phase), 2);
        step(1'b1, 8'h03, 1'b0, 1'b0);
        step(1'b1, 8'h04, 1'b0, 1'b0);
        check("t5_word2", input_data, 32'h01020304);
        idle(1, 1'b1);

        send_word(32'h10000001, 1'b0, 1'b0);
        send_word(32'h20000002, 1'b0, 1'b0);
        send_word(32'h30000003, 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b0, 1'b0);
        step(1'b1, 8'h88, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_ready", 32'(input_ready), 0);
        check("t6_count", 32'(count), 0);
        check("t6_phase", 32'(byte_phase), 0);
        check("t6_data", input_data, 32'h0);
        check("t6_ovf", 32'(overflow), 0);
        model_reset();
        @(posedge CLK);
        #1;
        reset_n = 1'b1;
        send_word(32'hFACE0B0E, 1'b0, 1'b0);
        check("t6_word", input_data, 32'hFACE0B0E);
        idle(1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
